// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares a single RAM port between CPUS processors, each with one
//   instruction port and one data port. A two-state FSM (IDLE, SERVE)
//   arbitrates in IDLE and holds the grant in SERVE for as long as the
//   owner keeps its request of the granted type asserted. This lets a
//   cache fill or write back several consecutive words under one grant.
//
//   Arbitration: data requests beat instruction requests. Within a class
//   the winner is the first requester found scanning upward from the
//   round-robin pointer rr, wrapping around. On release, rr moves to
//   owner+1.
//
// Ports
//   CLK, nRST         clock (rising edge); asynchronous active-low reset
//   iREN, iaddr       per-CPU instruction read request and word address
//   dREN, dWEN        per-CPU data read / write request
//   daddr, dstore     per-CPU data word address and write value
//   iwait, dwait      per-CPU stall; 0 marks the completion cycle
//   iload, dload      per-CPU read data (ramload broadcast to everyone)
//   ramREN, ramWEN    RAM read / write strobes
//   ramaddr, ramstore RAM address and write data
//   ramload           RAM read data
//   ramstate          RAM status: FREE, BUSY, ACCESS, ERROR

module mem_arbiter #(
    parameter int unsigned CPUS = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [CPUS-1:0]       iREN,
    input  logic [CPUS-1:0][31:0] iaddr,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    output logic [CPUS-1:0]       iwait,
    output logic [CPUS-1:0]       dwait,
    output logic [CPUS-1:0][31:0] iload,
    output logic [CPUS-1:0][31:0] dload,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  logic [1:0]            ramstate
);

    localparam int unsigned OW = (CPUS > 1) ? $clog2(CPUS) : 1;

    typedef enum logic {IDLE, SERVE} state_t;
    typedef enum logic {OT_I, OT_D} otype_t;
    typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_t;

    state_t          state;
    otype_t          otype;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   rr;

    logic [CPUS-1:0] d_req;
    logic [OW:0]     d_sel;
    logic [OW:0]     i_sel;
    logic            owner_req;
    logic            done;

    // Returns {found, index} of the first set bit of req, scanning upward
    // from start and wrapping past CPUS-1 back to 0.
    function automatic logic [OW:0] rr_pick(input logic [CPUS-1:0] req,
                                            input logic [OW-1:0]   start);
        logic [OW:0]  res;
        int unsigned  idx;
        res = '0;
        idx = 0;
        for (int unsigned k = 0; k < CPUS; k++) begin
            idx = (32'(start) + k) % CPUS;
            if (!res[OW] && req[OW'(idx)]) begin
                res = {1'b1, OW'(idx)};
            end
        end
        return res;
    endfunction

    assign d_req = dREN | dWEN;
    assign d_sel = rr_pick(d_req, rr);
    assign i_sel = rr_pick(iREN, rr);

    // Owner still wants the port for the class it was granted.
    assign owner_req = (otype == OT_D) ? d_req[owner] : iREN[owner];

    // Completion: serving a live request and the RAM reports ACCESS.
    assign done = (state == SERVE) && owner_req && (ramstate == RAM_ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            owner <= '0;
            otype <= OT_D;
            rr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_sel[OW]) begin
                        state <= SERVE;
                        owner <= d_sel[OW-1:0];
                        otype <= OT_D;
                    end else if (i_sel[OW]) begin
                        state <= SERVE;
                        owner <= i_sel[OW-1:0];
                        otype <= OT_I;
                    end
                end
                SERVE: begin
                    // Grant is released only when the owner drops its request;
                    // requests seen in this release cycle wait for the next IDLE.
                    if (!owner_req) begin
                        state <= IDLE;
                        rr    <= (owner == OW'(CPUS - 1)) ? '0 : owner + OW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM side follows the owner's port combinationally while it is served;
    // the asynchronous reset clears state, so strobes drop as soon as nRST falls.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (state == SERVE && owner_req) begin
            if (otype == OT_D) begin
                ramaddr = daddr[owner];
                if (dWEN[owner]) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore[owner];
                end else begin
                    ramREN = 1'b1;
                end
            end else begin
                ramaddr = iaddr[owner];
                ramREN  = 1'b1;
            end
        end
    end

    // A port with no request never stalls; a requesting port stalls unless
    // it is the owner of the matching class in its completion cycle.
    always_comb begin
        iwait = '0;
        dwait = '0;
        for (int unsigned c = 0; c < CPUS; c++) begin
            dwait[c] = d_req[c] && !(done && otype == OT_D && owner == OW'(c));
            iwait[c] = iREN[c]  && !(done && otype == OT_I && owner == OW'(c));
        end
    end

    always_comb begin
        iload = '0;
        dload = '0;
        for (int unsigned c = 0; c < CPUS; c++) begin
            iload[c] = ramload;
            dload[c] = ramload;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed-vector bench for mem_arbiter with CPUS=2. Inputs are driven
//   1 time unit after the rising edge; outputs are sampled 1 unit later.

module tb_mem_arbiter;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic            CLK = 1'b0;
    logic            nRST;
    logic [1:0]      iREN;
    logic [1:0][31:0] iaddr;
    logic [1:0]      dREN;
    logic [1:0]      dWEN;
    logic [1:0][31:0] daddr;
    logic [1:0][31:0] dstore;
    logic [1:0]      iwait;
    logic [1:0]      dwait;
    logic [1:0][31:0] iload;
    logic [1:0][31:0] dload;
    logic            ramREN;
    logic            ramWEN;
    logic [31:0]     ramaddr;
    logic [31:0]     ramstore;
    logic [31:0]     ramload;
    logic [1:0]      ramstate;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    mem_arbiter #(.CPUS(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs;
        iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = RS_FREE;
    endtask

    task automatic do_reset;
        clear_inputs();
        nRST = 1'b0;
        tick();
        #3 nRST = 1'b1;
    endtask

    logic [1:0] rs_tab [3];

    initial begin
        rs_tab[0] = RS_BUSY; rs_tab[1] = RS_ERROR; rs_tab[2] = RS_BUSY;

        // Reset state, with a data request from CPU1 pending.
        clear_inputs();
        nRST = 1'b0;
        tick();
        dREN[1] = 1'b1; daddr[1] = 32'h55; ramstate = RS_ACCESS;
        #1;
        check("rst_ramREN",   32'(ramREN), 32'd0);
        check("rst_ramWEN",   32'(ramWEN), 32'd0);
        check("rst_ramaddr",  ramaddr,     32'h0);
        check("rst_ramstore", ramstore,    32'h0);
        check("rst_dwait",    32'(dwait),  32'b10);
        check("rst_iwait",    32'(iwait),  32'b00);
        do_reset();

        // Single data read by CPU0.
        tick();
        dREN[0] = 1'b1; daddr[0] = 32'h40; ramstate = RS_ACCESS; ramload = 32'hDEADBEEF;
        #1;
        check("rd_idle_ramREN", 32'(ramREN),   32'd0);
        check("rd_idle_dwait0", 32'(dwait[0]), 32'd1);
        tick(); #1;
        check("rd_ramREN",  32'(ramREN),   32'd1);
        check("rd_ramWEN",  32'(ramWEN),   32'd0);
        check("rd_ramaddr", ramaddr,       32'h40);
        check("rd_dwait0",  32'(dwait[0]), 32'd0);
        check("rd_dload0",  dload[0],      32'hDEADBEEF);
        check("rd_iload1",  iload[1],      32'hDEADBEEF);
        tick();
        dREN[0] = 1'b0;
        #1;
        check("rd_rel_ramREN", 32'(ramREN),   32'd0);
        check("rd_rel_dwait0", 32'(dwait[0]), 32'd0);

        // Data beats instruction even when rr favours the instruction requester.
        do_reset();
        tick();
        iREN[0] = 1'b1; iaddr[0] = 32'h200;
        dWEN[1] = 1'b1; daddr[1] = 32'h80; dstore[1] = 32'h1234;
        ramstate = RS_ACCESS; ramload = 32'hCAFE0001;
        #1;
        check("pri_idle_iwait0", 32'(iwait[0]), 32'd1);
        check("pri_idle_dwait1", 32'(dwait[1]), 32'd1);
        tick(); #1;
        check("pri_ramWEN",   32'(ramWEN),   32'd1);
        check("pri_ramREN",   32'(ramREN),   32'd0);
        check("pri_ramaddr",  ramaddr,       32'h80);
        check("pri_ramstore", ramstore,      32'h1234);
        check("pri_dwait1",   32'(dwait[1]), 32'd0);
        check("pri_iwait0",   32'(iwait[0]), 32'd1);
        tick();
        dWEN[1] = 1'b0;
        #1;
        check("pri_rel_ramWEN", 32'(ramWEN),   32'd0);
        check("pri_rel_iwait0", 32'(iwait[0]), 32'd1);
        tick(); #1;
        check("pri_idle2_ramREN", 32'(ramREN),   32'd0);
        check("pri_idle2_iwait0", 32'(iwait[0]), 32'd1);
        tick(); #1;
        check("pri_i_ramREN",  32'(ramREN),   32'd1);
        check("pri_i_ramaddr", ramaddr,       32'h200);
        check("pri_i_iwait0",  32'(iwait[0]), 32'd0);
        check("pri_i_iload0",  iload[0],      32'hCAFE0001);
        tick();
        iREN[0] = 1'b0;
        #1;
        check("pri_i_rel_ramREN", 32'(ramREN), 32'd0);

        // Round robin between two continuous data readers.
        do_reset();
        tick();
        dREN = 2'b11; daddr[0] = 32'h10; daddr[1] = 32'h20; ramstate = RS_ACCESS;
        #1;
        check("rr_c0_ramREN", 32'(ramREN), 32'd0);
        tick(); #1;
        check("rr_c1_ramaddr", ramaddr,     32'h10);
        check("rr_c1_dwait",   32'(dwait),  32'b10);
        tick();
        dREN[0] = 1'b0;
        #1;
        check("rr_c2_ramREN", 32'(ramREN), 32'd0);
        check("rr_c2_dwait",  32'(dwait),  32'b10);
        tick();
        dREN[0] = 1'b1;
        #1;
        check("rr_c3_ramREN", 32'(ramREN), 32'd0);
        check("rr_c3_dwait",  32'(dwait),  32'b11);
        tick(); #1;
        check("rr_c4_ramaddr", ramaddr,    32'h20);
        check("rr_c4_dwait",   32'(dwait), 32'b01);
        tick();
        dREN[1] = 1'b0;
        #1;
        check("rr_c5_ramREN", 32'(ramREN), 32'd0);
        tick();
        dREN[1] = 1'b1;
        #1;
        check("rr_c6_ramREN", 32'(ramREN), 32'd0);
        tick(); #1;
        check("rr_c7_ramaddr", ramaddr,    32'h10);
        check("rr_c7_dwait",   32'(dwait), 32'b10);
        tick();
        dREN = 2'b00;
        #1;

        // Two-word fill under a single grant to CPU1; CPU0 stalls throughout.
        do_reset();
        tick();
        dREN[1] = 1'b1; daddr[1] = 32'h100; ramstate = RS_ACCESS;
        #1;
        tick();
        dREN[0] = 1'b1; daddr[0] = 32'h300;
        #1;
        check("blk_w0_ramaddr", ramaddr,    32'h100);
        check("blk_w0_dwait",   32'(dwait), 32'b01);
        tick();
        daddr[1] = 32'h104;
        #1;
        check("blk_w1_ramaddr", ramaddr,     32'h104);
        check("blk_w1_ramREN",  32'(ramREN), 32'd1);
        check("blk_w1_dwait",   32'(dwait),  32'b01);
        tick();
        dREN[1] = 1'b0;
        #1;
        check("blk_rel_ramREN", 32'(ramREN),   32'd0);
        check("blk_rel_dwait0", 32'(dwait[0]), 32'd1);
        tick(); #1;
        check("blk_idle_dwait0", 32'(dwait[0]), 32'd1);
        tick(); #1;
        check("blk_c0_ramaddr", ramaddr,       32'h300);
        check("blk_c0_dwait0",  32'(dwait[0]), 32'd0);
        tick();
        dREN[0] = 1'b0;
        #1;

        // RAM not ready for three cycles (BUSY/ERROR), then ACCESS.
        do_reset();
        tick();
        dREN[0] = 1'b1; daddr[0] = 32'h50; ramstate = RS_BUSY;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            ramstate = rs_tab[i];
            #1;
            check("nr_dwait0",  32'(dwait[0]), 32'd1);
            check("nr_ramREN",  32'(ramREN),   32'd1);
            check("nr_ramaddr", ramaddr,       32'h50);
        end
        tick();
        ramstate = RS_ACCESS;
        #1;
        check("nr_done_dwait0", 32'(dwait[0]), 32'd0);
        tick();
        dREN[0] = 1'b0;
        #1;
        check("nr_rel_dwait0", 32'(dwait[0]), 32'd0);
        // rr is now 1.

        // Reset during a write; next grant must come from rr=0.
        tick();
        dWEN[1] = 1'b1; daddr[1] = 32'h60; dstore[1] = 32'hAA;
        #1;
        tick(); #1;
        check("mr_pre_ramWEN", 32'(ramWEN), 32'd1);
        nRST = 1'b0;
        #1;
        check("mr_ramWEN",   32'(ramWEN),   32'd0);
        check("mr_ramaddr",  ramaddr,       32'h0);
        check("mr_dwait1",   32'(dwait[1]), 32'd1);
        #2 nRST = 1'b1;
        dREN[0] = 1'b1; daddr[0] = 32'h70;
        tick(); #1;
        check("mr_ramaddr2", ramaddr,     32'h70);
        check("mr_ramREN2",  32'(ramREN), 32'd1);
        check("mr_ramWEN2",  32'(ramWEN), 32'd0);
        check("mr_dwait2",   32'(dwait),  32'b10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
